// File: rtl/spi3w_adc_slave_if.sv
// Pin-level 3-wire SPI signals plus the register-write and frame-error sideband
// of the ADC configuration slave.
interface spi3w_adc_slave_if;
  logic       spi_clk_i;
  logic       spi_cs_n_i;
  logic       spi_data_i;
  logic       spi_data_o;
  logic       spi_data_oe_o;
  logic       reg_wr_stb_o;
  logic [6:0] reg_wr_addr_o;
  logic [7:0] reg_wr_data_o;
  logic       frame_err_o;

  modport slave (
    input  spi_clk_i,
    input  spi_cs_n_i,
    input  spi_data_i,
    output spi_data_o,
    output spi_data_oe_o,
    output reg_wr_stb_o,
    output reg_wr_addr_o,
    output reg_wr_data_o,
    output frame_err_o
  );

  modport master (
    output spi_clk_i,
    output spi_cs_n_i,
    output spi_data_i,
    input  spi_data_o,
    input  spi_data_oe_o,
    input  reg_wr_stb_o,
    input  reg_wr_addr_o,
    input  reg_wr_data_o,
    input  frame_err_o
  );
endinterface

// File: rtl/spi3w_adc_slave.sv
// 3-wire SPI register slave: 16-bit R/W frames oversampled on sys_clk_i,
// ID register at 0x00, g_num_regs-1 writable 8-bit registers above it.
module spi3w_adc_slave #(
  parameter logic [7:0]  g_id_value = 8'hA5,
  parameter int unsigned g_num_regs = 16   // at most 128 (7-bit address space)
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  spi3w_adc_slave_if.slave bus
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        clk_sync_q;
  logic [2:0]        cs_sync_q;
  logic [2:0]        din_sync_q;
  logic              clk_rise;
  logic              clk_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic              din;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [ADDR_W-1:0] shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] regs_q [g_num_regs];

  logic              data_q;
  logic              oe_q;
  logic              wr_stb_q;
  logic              frame_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              go_cmd;
  logic              shift_en;
  logic              cmd_done;
  logic              rd_load;
  logic              wr_commit;
  logic              tx_shift;
  logic              oe_set;
  logic              frame_end;
  logic              abort;

  // Two sync flops plus one history flop per pin; edges come from [1] vs [2]
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      clk_sync_q <= '0;
      cs_sync_q  <= '0;
      din_sync_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.spi_clk_i};
      cs_sync_q  <= {cs_sync_q[1:0],  bus.spi_cs_n_i};
      din_sync_q <= {din_sync_q[1:0], bus.spi_data_i};
    end
  end

  assign clk_rise  =  clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall  = ~clk_sync_q[1] &  clk_sync_q[2];
  assign cs_rise   =  cs_sync_q[1]  & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1]  &  cs_sync_q[2];
  assign din       =  din_sync_q[2];
  assign shift_nxt = {shift_q, din};

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CS rising edge wins over any spi_clk edge seen in the same cycle
  always_comb begin
    state_d   = state_q;
    go_cmd    = 1'b0;
    shift_en  = 1'b0;
    cmd_done  = 1'b0;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    tx_shift  = 1'b0;
    oe_set    = 1'b0;
    frame_end = 1'b0;
    abort     = 1'b0;
    if (cs_rise) begin
      state_d   = ST_IDLE;
      frame_end = 1'b1;
      abort     = (state_q == ST_CMD) || (state_q == ST_WR_DATA) ||
                  (state_q == ST_RD_DATA);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            go_cmd  = 1'b1;
          end
        end
        ST_CMD: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt_q == CNT_W'(7)) begin
              cmd_done = 1'b1;
              rd_load  = shift_nxt[7];
              state_d  = shift_nxt[7] ? ST_RD_DATA : ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt_q == CNT_W'(15)) begin
              wr_commit = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
        ST_RD_DATA: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt_q == CNT_W'(15)) begin
              state_d = ST_DONE;
            end
          end else if (clk_fall) begin
            tx_shift = 1'b1;
            oe_set   = (bit_cnt_q == CNT_W'(8));
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Read mux: ID at 0x00, zero for unimplemented addresses
  always_comb begin
    rd_val = '0;
    if (shift_nxt[ADDR_W-1:0] == '0) begin
      rd_val = g_id_value;
    end else begin
      for (int i = 1; i < int'(g_num_regs); i++) begin
        if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) begin
          rd_val = regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      data_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < int'(g_num_regs); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_stb_q    <= wr_commit;
      frame_err_q <= abort;
      if (go_cmd) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_en) begin
        shift_q <= shift_nxt[ADDR_W-1:0];
      end
      if (cmd_done) begin
        addr_q <= shift_nxt[ADDR_W-1:0];
      end
      if (rd_load) begin
        tx_q <= rd_val;
      end
      if (wr_commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= shift_nxt;
      end
      // Address 0x00 and out-of-range addresses match no storage slot
      for (int i = 1; i < int'(g_num_regs); i++) begin
        if (wr_commit && (addr_q == ADDR_W'(i))) begin
          regs_q[i] <= shift_nxt;
        end
      end
      if (frame_end) begin
        oe_q   <= 1'b0;
        data_q <= 1'b0;
      end else if (tx_shift) begin
        data_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
        if (oe_set) begin
          oe_q <= 1'b1;
        end
      end
    end
  end

  assign bus.spi_data_o    = data_q;
  assign bus.spi_data_oe_o = oe_q;
  assign bus.reg_wr_stb_o  = wr_stb_q;
  assign bus.reg_wr_addr_o = wr_addr_q;
  assign bus.reg_wr_data_o = wr_data_q;
  assign bus.frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi3w_adc_slave.sv
// Directed bench for spi3w_adc_slave: bit-banged SPI master, register-map
// model with expected write/error event queues, per-cycle output checker.
module tb_spi3w_adc_slave;

  localparam int HP = 8;   // sys_clk cycles per spi_clk half period

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic sys_clk_i = 1'b0;
  logic sys_rst_i = 1'b1;
  logic m_clk     = 1'b0;
  logic m_cs      = 1'b1;
  logic mdrv      = 1'b1;

  spi3w_adc_slave_if bus();

  spi3w_adc_slave #(
    .g_id_value (8'hA5),
    .g_num_regs (16)
  ) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .bus       (bus)
  );

  // Shared data pin: slave wins when enabled, otherwise master (idle high)
  assign bus.spi_clk_i  = m_clk;
  assign bus.spi_cs_n_i = m_cs;
  assign bus.spi_data_i = bus.spi_data_oe_o ? bus.spi_data_o : mdrv;

  always #5 sys_clk_i = ~sys_clk_i;

  logic [7:0] exp_regs [16];
  wr_t        exp_wr [$];
  int         exp_err  = 0;
  logic [6:0] last_a   = '0;
  logic [7:0] last_d   = '0;
  logic       oe_ok    = 1'b0;
  logic       chk_en   = 1'b0;
  logic       prev_stb = 1'b0;
  logic       prev_err = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    if (a == 7'h00) return 8'hA5;
    if (a >= 7'd16) return 8'h00;
    return exp_regs[a[3:0]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    last_a = '0;
    last_d = '0;
  endtask

  // Per-cycle checker: pulses must match expected events, oe only in read windows
  always @(negedge sys_clk_i) begin
    if (chk_en) begin
      if (bus.reg_wr_stb_o === 1'b1) begin
        chk(!prev_stb, "stb_one_cycle", 32'(prev_stb), 32'd0);
        chk(exp_wr.size() > 0, "stb_expected", 32'd1, 32'(exp_wr.size()));
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          last_a = w.a;
          last_d = w.d;
        end
      end
      chk(bus.reg_wr_addr_o === last_a, "wr_addr", 32'(bus.reg_wr_addr_o), 32'(last_a));
      chk(bus.reg_wr_data_o === last_d, "wr_data", 32'(bus.reg_wr_data_o), 32'(last_d));
      if (bus.frame_err_o === 1'b1) begin
        chk(!prev_err, "err_one_cycle", 32'(prev_err), 32'd0);
        chk(exp_err > 0, "err_expected", 32'd1, 32'(exp_err));
        if (exp_err > 0) exp_err--;
      end
      if (!oe_ok) chk(bus.spi_data_oe_o === 1'b0, "oe_idle", 32'(bus.spi_data_oe_o), 32'd0);
      prev_stb = bus.reg_wr_stb_o;
      prev_err = bus.frame_err_o;
    end
  end

  // One master frame; nclk<16 or cs_last aborts, rst_at pulses reset after that rising edge
  task automatic frame(input logic [15:0] w, input int nclk, input bit cs_last,
                       input int rst_at, output logic [7:0] rd);
    bit is_rd;
    bit stop;
    is_rd = w[15];
    stop  = 1'b0;
    rd    = 8'h00;
    if (rst_at < 0) begin
      if (nclk < 16 || cs_last) exp_err++;
      else if (!is_rd) begin
        if (w[14:8] != 7'h00 && w[14:8] < 7'd16) exp_regs[w[11:8]] = w[7:0];
        exp_wr.push_back({w[14:8], w[7:0]});
      end
    end
    @(negedge sys_clk_i);
    m_cs = 1'b0;
    for (int i = 0; i < nclk && !stop; i++) begin
      mdrv = (is_rd && i >= 8) ? 1'b1 : w[15-i];
      repeat (HP) @(negedge sys_clk_i);
      m_clk = 1'b1;
      if (cs_last && i == nclk - 1) begin
        m_cs = 1'b1;
        stop = 1'b1;
      end else begin
        if (is_rd && i >= 8) begin
          chk(bus.spi_data_oe_o === 1'b1, "rd_oe", 32'(bus.spi_data_oe_o), 32'd1);
          rd[15-i] = bus.spi_data_i;
        end
        if (i == rst_at) begin
          repeat (HP/2) @(negedge sys_clk_i);
          chk(bus.spi_data_oe_o === 1'b1, "oe_before_rst", 32'(bus.spi_data_oe_o), 32'd1);
          sys_rst_i = 1'b1;
          @(posedge sys_clk_i);
          #1;
          chk(bus.spi_data_oe_o === 1'b0, "oe_after_rst", 32'(bus.spi_data_oe_o), 32'd0);
          model_clear();
          oe_ok = 1'b0;
          @(negedge sys_clk_i);
          sys_rst_i = 1'b0;
          stop = 1'b1;
        end else begin
          repeat (HP) @(negedge sys_clk_i);
          m_clk = 1'b0;
          if (is_rd && i == 7) oe_ok = 1'b1;
        end
      end
    end
    repeat (HP) @(negedge sys_clk_i);
    m_clk = 1'b0;
    repeat (HP) @(negedge sys_clk_i);
    m_cs = 1'b1;
    mdrv = 1'b1;
    repeat (6) @(negedge sys_clk_i);
    oe_ok = 1'b0;
    repeat (2*HP) @(negedge sys_clk_i);
    chk(exp_wr.size() == 0, "stb_missing", 32'(exp_wr.size()), 32'd0);
    chk(exp_err == 0, "err_missing", 32'(exp_err), 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r;
    frame({1'b0, a, d}, 16, 1'b0, -1, r);
  endtask

  task automatic rd_chk(input logic [6:0] a, input logic [7:0] lit, input string nm);
    logic [7:0] r;
    logic [7:0] m;
    m = model_rd(a);
    frame({1'b1, a, 8'h00}, 16, 1'b0, -1, r);
    chk(r === m, nm, 32'(r), 32'(m));
    chk(r === lit, {nm, "_lit"}, 32'(r), 32'(lit));
  endtask

  initial begin
    logic [7:0] r;
    model_clear();
    repeat (4) @(negedge sys_clk_i);
    chk(bus.spi_data_o === 1'b0,    "rst_data_o",  32'(bus.spi_data_o),    32'd0);
    chk(bus.spi_data_oe_o === 1'b0, "rst_oe",      32'(bus.spi_data_oe_o), 32'd0);
    chk(bus.reg_wr_stb_o === 1'b0,  "rst_stb",     32'(bus.reg_wr_stb_o),  32'd0);
    chk(bus.frame_err_o === 1'b0,   "rst_err",     32'(bus.frame_err_o),   32'd0);
    chk(bus.reg_wr_addr_o === 7'h0, "rst_wr_addr", 32'(bus.reg_wr_addr_o), 32'd0);
    chk(bus.reg_wr_data_o === 8'h0, "rst_wr_data", 32'(bus.reg_wr_data_o), 32'd0);
    chk_en = 1'b1;
    sys_rst_i = 1'b0;
    repeat (8) @(negedge sys_clk_i);

    wr(7'h03, 8'h55);
    rd_chk(7'h03, 8'h55, "rd_03");
    rd_chk(7'h00, 8'hA5, "rd_id");
    rd_chk(7'h7F, 8'h00, "rd_7f");
    wr(7'h00, 8'hFF);
    rd_chk(7'h00, 8'hA5, "rd_id_after_wr");
    wr(7'h7F, 8'h12);
    rd_chk(7'h7F, 8'h00, "rd_7f_after_wr");
    wr(7'h0F, 8'hC3);
    rd_chk(7'h0F, 8'hC3, "rd_0f");
    wr(7'h10, 8'h9A);
    rd_chk(7'h10, 8'h00, "rd_10");

    wr(7'h05, 8'h33);
    frame(16'h05AA, 10, 1'b0, -1, r);
    rd_chk(7'h05, 8'h33, "rd_05_after_abort");

    frame(16'h0644, 16, 1'b1, -1, r);
    rd_chk(7'h06, 8'h00, "rd_06_cs_clk_same");

    frame(16'h8300, 16, 1'b0, 12, r);
    rd_chk(7'h03, 8'h00, "rd_03_after_rst");
    wr(7'h03, 8'h77);
    rd_chk(7'h03, 8'h77, "rd_03_new");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi3w_adc_slave.md
SPI3W_ADC_SLAVE -- requirements
Module: spi3w_adc_slave

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter g_id_value, default 8'hA5, SHALL be the read-only contents of register 0x00.
REQ-003 Parameter g_num_regs, default 16, SHALL be the number of implemented 8-bit registers at addresses 0..g_num_regs-1.
REQ-004 Port sys_clk_i, input, 1, SHALL be the system clock; all logic is clocked on its rising edge.
REQ-005 Port sys_rst_i, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port spi_clk_i, input, 1, SHALL be the SPI clock from the master, asynchronous, CPOL=0.
REQ-007 Port spi_cs_n_i, input, 1, SHALL be the active-low chip select, asynchronous.
REQ-008 Port spi_data_i, input, 1, SHALL be the sampled value of the shared 3-wire data pin.
REQ-009 Port spi_data_o, output, 1, SHALL be the value the slave drives onto the data pin.
REQ-010 Port spi_data_oe_o, output, 1, SHALL be the tristate enable; when 1 the slave drives the pin.
REQ-011 Port reg_wr_stb_o, output, 1, SHALL be a one-cycle pulse on each committed register write.
REQ-012 Port reg_wr_addr_o, output, 7, and reg_wr_data_o, output, 8, SHALL carry the address and data of the last committed write.
REQ-013 Port frame_err_o, output, 1, SHALL be a one-cycle pulse on each aborted frame.

Function
REQ-014 spi_clk_i, spi_cs_n_i and spi_data_i SHALL each pass a 2-FF synchronizer plus one edge-detect register; an internal event occurs 3 sys_clk cycles after the pin transition.
REQ-015 Correct operation SHALL require sys_clk_i frequency >= 8x spi_clk_i frequency.
REQ-016 Frame format SHALL be 16 bits, MSB first: bit15 R/W (1 = read), bits14:8 address, bits7:0 data.
REQ-017 The slave SHALL sample spi_data_i on each detected rising spi_clk edge while CS is low.
REQ-018 The slave SHALL update spi_data_o only on detected falling spi_clk edges.
REQ-019 FSM states SHALL be IDLE, CMD, WR_DATA, RD_DATA, DONE.
REQ-020 IDLE -> CMD SHALL occur on the detected CS falling edge; the bit counter SHALL clear to 0.
REQ-021 CMD SHALL shift in 8 bits; after the 8th rising edge it SHALL go to RD_DATA if R/W=1, else WR_DATA.
REQ-022 WR_DATA SHALL shift in 8 bits; on the 16th rising edge it SHALL go to DONE.
REQ-023 The write SHALL commit in the cycle after the 16th rising edge is detected: register updated, reg_wr_stb_o=1 for one cycle, reg_wr_addr_o/reg_wr_data_o updated.
REQ-024 Writes to address 0x00 or to addresses >= g_num_regs SHALL update no register but SHALL still pulse reg_wr_stb_o.
REQ-025 On entering RD_DATA the slave SHALL load the addressed register (0x00 -> g_id_value; addresses >= g_num_regs -> 8'h00) into the shift-out register.
REQ-026 On the 8th falling edge the slave SHALL assert spi_data_oe_o and drive bit7; falling edges 9..15 SHALL drive bits 6..0.
REQ-027 After the 16th rising edge in RD_DATA the FSM SHALL go to DONE; spi_data_oe_o SHALL stay 1 and spi_data_o SHALL hold bit0.
REQ-028 In DONE, further spi_clk edges SHALL be ignored.
REQ-029 A detected CS rising edge in any state SHALL return the FSM to IDLE and deassert spi_data_oe_o in the same cycle.
REQ-030 A CS rising edge before the 16th rising edge SHALL pulse frame_err_o for one cycle and commit no write.
REQ-031 A CS falling edge detected while not in IDLE SHALL be ignored.
REQ-032 If CS rises and spi_clk rises in the same sys_clk cycle, the CS event SHALL take priority and the clock edge SHALL be discarded.
REQ-033 spi_data_oe_o SHALL be 0 in every state other than RD_DATA after the 8th falling edge, and DONE following a read.

Reset
REQ-034 On reset the FSM SHALL enter IDLE, and the synchronizers and bit counter SHALL clear.
REQ-035 On reset all registers SHALL clear to 8'h00; spi_data_o, spi_data_oe_o, reg_wr_stb_o, frame_err_o, reg_wr_addr_o and reg_wr_data_o SHALL all be 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame silently: no write and no frame_err_o pulse; the slave SHALL then wait for a fresh CS falling edge.

Verification
REQ-037 Write frame 0x0355 (addr 0x03, data 0x55) -> reg_wr_stb_o pulses once with addr 0x03 and data 0x55; spi_data_oe_o stays 0 throughout.
REQ-038 Write 0x0355, then read frame 0x8300 -> spi_data_oe_o rises at the 8th falling edge and the master samples 0x55 MSB first.
REQ-039 Read frame 0x8000 -> returns 0xA5; read of address 0x7F -> returns 0x00.
REQ-040 Write 0x00FF, then read 0x8000 -> reg_wr_stb_o pulses, and the read still returns 0xA5.
REQ-041 Raise CS after 10 clocks of a write to 0x05 -> frame_err_o pulses once, no reg_wr_stb_o, and register 0x05 keeps its old value.
REQ-042 Assert sys_rst_i during bit 12 of a read -> spi_data_oe_o is 0 the next cycle; the next full frame completes correctly.
